imem_fetch_ctrl: RTL and testbench



---
 rtl/imem_fetch_ctrl.sv | 118 +++++++++++
 tb/tb_imem_fetch_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// ============================================================================
// Module   : imem_fetch_ctrl
// Purpose  : Instruction-fetch controller; owns the PC, issues one read per cycle
//            into a 1-cycle-latency memory and buffers results in a 2-entry FIFO.
// Options  : FETCH_ALIGN_CHECK_EN - flag misaligned redirects via fetch_fault
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic [ADDR_WIDTH-1:0] imem_address,
  input  logic [31:0]           imem_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst_data,
  output logic [31:0]           inst_pc,
  output logic                  fetch_fault
);

  logic [31:0] r_pc;
  logic        r_inflight;
  logic [31:0] r_inflight_pc;
  logic [1:0]  r_count;
  logic [31:0] r_data [2];
  logic [31:0] r_epc  [2];

  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic        w_fault;
  logic [1:0]  w_occ;
  logic [1:0]  w_wslot;
  logic [31:0] w_load_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_fault;

  // Fault tracks the alignment of the most recent redirect target.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else if (redirect_valid) begin
      r_fault <= |redirect_pc[1:0];
    end
  end

  assign w_fault   = r_fault;
  assign w_load_pc = redirect_pc;
`else
  logic w_unused_low;

  assign w_unused_low = ^redirect_pc[1:0];
  assign w_fault      = 1'b0;
  assign w_load_pc    = {redirect_pc[31:2], 2'b00};
`endif

  assign fetch_fault  = w_fault;
  assign imem_address = r_pc[ADDR_WIDTH+1:2];
  assign inst_valid   = (r_count != 2'd0);
  assign inst_data    = r_data[0];
  assign inst_pc      = r_epc[0];

  assign w_pop   = inst_valid & inst_ready;
  assign w_push  = r_inflight & ~redirect_valid;
  // Occupancy after this edge's pop, counting the read still in the memory pipe.
  assign w_occ   = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_issue = enable & ~redirect_valid & ~w_fault & (w_occ < 2'd2);
  assign w_wslot = r_count - {1'b0, w_pop};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'd0;
      r_count       <= 2'd0;
      r_data[0]     <= 32'd0;
      r_data[1]     <= 32'd0;
      r_epc[0]      <= 32'd0;
      r_epc[1]      <= 32'd0;
    end else if (redirect_valid) begin
      r_pc       <= w_load_pc;
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + 32'd4;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (w_pop) begin
        r_data[0] <= r_data[1];
        r_epc[0]  <= r_epc[1];
      end
      // The push slot is computed after the pop so it overrides the shift.
      if (w_push) begin
        if (w_wslot == 2'd0) begin
          r_data[0] <= imem_data;
          r_epc[0]  <= r_inflight_pc;
        end else begin
          r_data[1] <= imem_data;
          r_epc[1]  <= r_inflight_pc;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
// ============================================================================
// Module   : tb_imem_fetch_ctrl
// Purpose  : Self-checking bench for imem_fetch_ctrl; an in-order instruction
//            stream model plus directed latency/backpressure/wrap scenarios.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_fetch_ctrl;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [9:0]  imem_address;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  imem_fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .ADDR_WIDTH (10)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_address   (imem_address),
    .imem_data      (imem_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous instruction memory with one cycle of read latency.
  logic [31:0] mem [1024];
  initial imem_data = 32'd0;
  always @(posedge clock) imem_data <= mem[imem_address];

  int          checks;
  int          errors;
  logic [31:0] exp_pc;
  bit          m_fault;
  bit          prev_hold;
  logic [31:0] prev_data;
  logic [31:0] prev_pc;
  logic [31:0] tmp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Called at a falling edge: drives inputs, checks the visible state against
  // the stream model, updates the model for the coming rising edge, then
  // advances to the next falling edge.
  task automatic step(input bit en, input bit rdy, input bit rv, input logic [31:0] rpc);
    enable         = en;
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    chk("fault", {31'd0, fetch_fault}, {31'd0, m_fault});
    if (prev_hold) begin
      chk("hold_valid", {31'd0, inst_valid}, 32'd1);
      chk("hold_data", inst_data, prev_data);
      chk("hold_pc", inst_pc, prev_pc);
    end
    if (m_fault) chk("fault_idle", {31'd0, inst_valid}, 32'd0);
    if (inst_valid && rdy) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst_data", inst_data, mem[exp_pc[11:2]]);
      exp_pc = exp_pc + 32'd4;
    end
    prev_hold = inst_valid && !rdy && !rv;
    prev_data = inst_data;
    prev_pc   = inst_pc;
    if (rv) begin
`ifdef FETCH_ALIGN_CHECK_EN
      m_fault = (rpc[1:0] != 2'b00);
      exp_pc  = rpc;
`else
      exp_pc  = {rpc[31:2], 2'b00};
`endif
    end
    @(negedge clock);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_fault = 1'b0;
    prev_hold = 1'b0;
    prev_data = 32'd0;
    prev_pc = 32'd0;
    exp_pc = 32'd0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    reset = 1'b1;
    enable = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    repeat (3) @(negedge clock);

    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_data", inst_data, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_addr", {22'd0, imem_address}, 32'd0);

    // Reset release: first instruction visible after the second rising edge.
    reset = 1'b0;
    step(1, 1, 0, 32'd0);
    chk("lat_edge1", {31'd0, inst_valid}, 32'd0);
    step(1, 1, 0, 32'd0);
    chk("first_valid", {31'd0, inst_valid}, 32'd1);
    chk("first_pc", inst_pc, 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("throughput", {31'd0, inst_valid}, 32'd1);
      step(1, 1, 0, 32'd0);
    end

    // Backpressure: two buffered, no read in flight, pc two words past head.
    repeat (5) step(1, 0, 0, 32'd0);
    tmp = inst_pc + 32'd8;
    chk("bp_valid", {31'd0, inst_valid}, 32'd1);
    chk("bp_addr", {22'd0, imem_address}, {22'd0, tmp[11:2]});
    repeat (3) step(1, 1, 0, 32'd0);

    // Redirect into a busy pipeline; stale work must never reach decode.
    repeat (3) step(1, 0, 0, 32'd0);
    step(1, 0, 1, 32'h40);
    chk("rd_addr", {22'd0, imem_address}, 32'h10);
    chk("rd_flush", {31'd0, inst_valid}, 32'd0);
    step(1, 1, 0, 32'd0);
    chk("rd_lat1", {31'd0, inst_valid}, 32'd0);
    step(1, 1, 0, 32'd0);
    chk("rd_valid", {31'd0, inst_valid}, 32'd1);
    chk("rd_pc", inst_pc, 32'h40);
    repeat (4) step(1, 1, 0, 32'd0);

    // Enable low: the in-flight word drains, then the stream stops.
    repeat (4) step(0, 1, 0, 32'd0);
    chk("en_low_idle", {31'd0, inst_valid}, 32'd0);
    repeat (6) step(1, 1, 0, 32'd0);

    // Address wrap past the top of a 1024-word memory.
    step(1, 0, 1, 32'hFFC);
    chk("wrap_addr", {22'd0, imem_address}, 32'd1023);
    step(1, 1, 0, 32'd0);
    step(1, 1, 0, 32'd0);
    chk("wrap_pc0", inst_pc, 32'hFFC);
    step(1, 1, 0, 32'd0);
    chk("wrap_pc1", inst_pc, 32'h1000);
    repeat (3) step(1, 1, 0, 32'd0);

    // Misaligned redirect, then an aligned one.
    step(1, 1, 1, 32'h42);
    step(1, 1, 0, 32'd0);
    step(1, 1, 0, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
    chk("mis_idle", {31'd0, inst_valid}, 32'd0);
`else
    chk("mis_pc", inst_pc, 32'h40);
`endif
    step(1, 1, 1, 32'h44);
    step(1, 1, 0, 32'd0);
    step(1, 1, 0, 32'd0);
    chk("al_fault", {31'd0, fetch_fault}, 32'd0);
    chk("al_pc", inst_pc, 32'h44);

    // Randomised traffic against the stream model.
    for (int i = 0; i < 3000; i++) begin
      bit          rv;
      logic [31:0] rpc;
      rv  = ($urandom_range(0, 15) == 0);
      rpc = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 3) == 0) rpc = rpc | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) rpc = 32'hFF8;
      step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, rv, rpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
